polyvec_reduce_ctrl: RTL and testbench

POLYVEC_REDUCE_CTRL -- requirements
Module: polyvec_reduce_ctrl

---
 rtl/polyvec_reduce_pkg.sv | 18 +
 rtl/polyvec_reduce_wdog.sv | 38 +++
 rtl/polyvec_reduce_ctrl.sv | 154 +++++++++++++++
 tb/tb_polyvec_reduce_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyvec_reduce_pkg.sv
// Shared types and constants for the polynomial-vector reduce controller.
// Defaults here feed the top-level parameters; the watchdog counter is WDOG_W bits.
package polyvec_reduce_pkg;

  localparam int KYBER_K         = 2;
  localparam int KYBER_Q         = 3329;
  localparam int TIMEOUT_CYC_DEF = 511;
  localparam int WDOG_W          = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_NEXT      = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

endpackage

// File: rtl/polyvec_reduce_wdog.sv
// WAIT_DONE watchdog: counts cycles in WAIT_DONE, flags expiry combinationally on the last allowed cycle.
// No backpressure; clr has priority over counting.
module polyvec_reduce_wdog #(
  parameter int TIMEOUT_CYC = polyvec_reduce_pkg::TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);
  import polyvec_reduce_pkg::*;

  // Count k on the k-th WAIT_DONE cycle, so expiry fires TIMEOUT_CYC cycles after entry.
  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = cnt_en && (cnt_q == LIMIT);

endmodule

// File: rtl/polyvec_reduce_ctrl.sv
// Sequences KYBER_K reduce-engine launches and arbitrates coefficient-RAM ownership with the host; start-to-launch is 1 cycle.
// No backpressure: a start seen while the host owns the RAM is held pending; POLYVEC_REDUCE_TIMEOUT_EN adds a WAIT_DONE watchdog driving err.
module polyvec_reduce_ctrl #(
  parameter int KYBER_K     = polyvec_reduce_pkg::KYBER_K,
  parameter int TIMEOUT_CYC = polyvec_reduce_pkg::TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       eng_done,
  input  logic       host_req,
  output logic       eng_enable,
  output logic [1:0] poly_sel,
  output logic       busy,
  output logic       done,
  output logic       host_gnt,
  output logic       err
);
  import polyvec_reduce_pkg::*;

  if (KYBER_K < 2 || KYBER_K > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 511) begin : g_cfg_check
    $error("polyvec_reduce_ctrl: KYBER_K or TIMEOUT_CYC out of range");
  end

  localparam logic [1:0] LAST_SEL = 2'(KYBER_K - 1);

  state_e     state_q, state_d;
  logic [1:0] poly_sel_q, poly_sel_d;
  logic       eng_enable_q, eng_enable_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       host_gnt_q, host_gnt_d;
  logic       pending_q, pending_d;
  logic       accept;
  logic       timeout;

`ifdef POLYVEC_REDUCE_TIMEOUT_EN
  logic err_q, err_d;

  polyvec_reduce_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == ST_LAUNCH),
    .cnt_en  (state_q == ST_WAIT_DONE),
    .expired (timeout)
  );

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (state_q == ST_WAIT_DONE && timeout && !eng_done) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // A fresh start beats a same-cycle host_req; a pending start waits for the host to let go.
  assign accept = (state_q == ST_IDLE) && !host_gnt_q && (start || (pending_q && !host_req));

  always_comb begin
    state_d    = state_q;
    poly_sel_d = poly_sel_q;
    pending_d  = pending_q;
    host_gnt_d = host_gnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_LAUNCH;
          poly_sel_d = '0;
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (eng_done) begin
          state_d = ST_NEXT;
        end else if (timeout) begin
          state_d = ST_FINISH;
        end
      end
      ST_NEXT: begin
        if (poly_sel_q == LAST_SEL) begin
          state_d = ST_FINISH;
        end else begin
          poly_sel_d = poly_sel_q + 2'd1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (accept) begin
      pending_d = 1'b0;
    end else if (state_q == ST_IDLE && start && host_gnt_q) begin
      pending_d = 1'b1;
    end

    // Granting out of FINISH hands the RAM over the same cycle busy drops.
    if (host_gnt_q) begin
      host_gnt_d = host_req;
    end else begin
      host_gnt_d = host_req && !pending_q &&
                   ((state_q == ST_IDLE && !start) || state_q == ST_FINISH);
    end

    eng_enable_d = (state_d == ST_LAUNCH);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      poly_sel_q   <= '0;
      eng_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      host_gnt_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      poly_sel_q   <= poly_sel_d;
      eng_enable_q <= eng_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      host_gnt_q   <= host_gnt_d;
      pending_q    <= pending_d;
    end
  end

  assign eng_enable = eng_enable_q;
  assign poly_sel   = poly_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign host_gnt   = host_gnt_q;

endmodule

// File: tb/tb_polyvec_reduce_ctrl.sv
// Bench for polyvec_reduce_ctrl: behavioural engine responder plus event logs checked against timelines from the launch/next/finish rules.
// Build with POLYVEC_REDUCE_TIMEOUT_EN defined to exercise the watchdog scenario.
module tb_polyvec_reduce_ctrl;
  localparam int K = 2;
  localparam int TMO = 511;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       host_req = 1'b0;
  logic       eng_done_auto = 1'b0;
  logic       eng_done_man = 1'b0;
  logic       eng_done;
  logic       eng_enable, busy, done, host_gnt, err;
  logic [1:0] poly_sel;

  assign eng_done = eng_done_auto | eng_done_man;

  polyvec_reduce_ctrl #(.KYBER_K(K), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .eng_done   (eng_done),
    .host_req   (host_req),
    .eng_enable (eng_enable),
    .poly_sel   (poly_sel),
    .busy       (busy),
    .done       (done),
    .host_gnt   (host_gnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int eng_lat = 10;
  bit eng_auto = 1'b1;
  int eng_target = -1;
  int en_cyc_q[$];
  int en_sel_q[$];
  int done_cyc_q[$];
  int done_err_q[$];

  int         s_cyc;
  logic       s_eng_enable, s_busy, s_done, s_host_gnt, s_err;
  logic [1:0] s_poly_sel;

  // One cycle: sample mid-cycle, log events, advance; the engine answers eng_lat cycles after each launch.
  task automatic tick();
    @(negedge clk);
    s_cyc = cyc; s_eng_enable = eng_enable; s_poly_sel = poly_sel;
    s_busy = busy; s_done = done; s_host_gnt = host_gnt; s_err = err;
    if (!reset_n) begin
      eng_target = -1;
    end else if (eng_enable) begin
      en_cyc_q.push_back(cyc);
      en_sel_q.push_back(int'(poly_sel));
      eng_target = cyc + eng_lat;
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(int'(err));
    end
    @(posedge clk);
    #1;
    cyc++;
    eng_done_auto = eng_auto && (cyc == eng_target);
  endtask

  task automatic run_to_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!s_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int t0;
    bit ok;
    reset_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({s_eng_enable, s_poly_sel, s_busy, s_done, s_host_gnt, s_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b required=0000000",
               {s_eng_enable, s_poly_sel, s_busy, s_done, s_host_gnt, s_err});
    end
    eng_lat = 4;
    reset_n = 1'b1; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if (s_cyc !== t0 + 1 || s_eng_enable !== 1'b1 || s_busy !== 1'b1 || s_poly_sel !== 2'd0) begin
      n_err++;
      $display("FAIL start_after_reset en=%b busy=%b sel=%0d required en=1 busy=1 sel=0",
               s_eng_enable, s_busy, s_poly_sel);
    end
    run_to_idle(100, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_run_idle busy stuck required idle"); end
  endtask

  task automatic test_basic_k2();
    int t0, be, bd, lat, exp_done;
    bit ok;
    lat = 262; eng_lat = lat;
    be = en_cyc_q.size(); bd = done_cyc_q.size();
    t0 = cyc; start = 1'b1; tick(); start = 1'b0;
    run_to_idle(2000, ok);
    exp_done = t0 + 1 + K * (lat + 2);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_idle busy stuck required idle"); end
    n_vec++;
    if (en_cyc_q.size() - be !== K) begin
      n_err++;
      $display("FAIL basic_launch_count got=%0d required=%0d", en_cyc_q.size() - be, K);
    end else begin
      for (int i = 0; i < K; i++) begin
        n_vec++;
        if (en_cyc_q[be+i] !== t0 + 1 + i * (lat + 2) || en_sel_q[be+i] !== i) begin
          n_err++;
          $display("FAIL basic_launch%0d got cyc=%0d sel=%0d required cyc=%0d sel=%0d",
                   i, en_cyc_q[be+i] - t0, en_sel_q[be+i], 1 + i * (lat + 2), i);
        end
      end
    end
    n_vec++;
    if (done_cyc_q.size() !== bd + 1 || done_cyc_q[bd] !== exp_done || done_err_q[bd] !== 0) begin
      n_err++;
      $display("FAIL basic_done count=%0d required=1, at=%0d required=%0d",
               done_cyc_q.size() - bd, done_cyc_q[bd] - t0, exp_done - t0);
    end
    n_vec++;
    if (s_cyc !== exp_done + 1) begin
      n_err++;
      $display("FAIL basic_busy_drop got=%0d required=%0d", s_cyc - t0, exp_done + 1 - t0);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      int t0, be, bd, lat, gap;
      bit ok;
      lat = $urandom_range(1, 40);
      gap = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        eng_done_man = 1'b1; tick(); eng_done_man = 1'b0;
      end
      repeat (gap) tick();
      eng_lat = lat;
      be = en_cyc_q.size(); bd = done_cyc_q.size();
      t0 = cyc; start = 1'b1; tick(); start = 1'b0;
      run_to_idle(K * (lat + 4) + 20, ok);
      n_vec++;
      if (!ok || en_cyc_q.size() - be !== K) begin
        n_err++;
        $display("FAIL rand%0d_launches idle=%0b count=%0d required idle count=%0d",
                 r, ok, en_cyc_q.size() - be, K);
      end else begin
        for (int i = 0; i < K; i++) begin
          n_vec++;
          if (en_cyc_q[be+i] !== t0 + 1 + i * (lat + 2) || en_sel_q[be+i] !== i) begin
            n_err++;
            $display("FAIL rand%0d_launch%0d lat=%0d got cyc=%0d sel=%0d required cyc=%0d sel=%0d",
                     r, i, lat, en_cyc_q[be+i] - t0, en_sel_q[be+i], 1 + i * (lat + 2), i);
          end
        end
      end
      n_vec++;
      if (done_cyc_q.size() !== bd + 1 || done_cyc_q[bd] !== t0 + 1 + K * (lat + 2)) begin
        n_err++;
        $display("FAIL rand%0d_done lat=%0d count=%0d at=%0d required one at %0d",
                 r, lat, done_cyc_q.size() - bd, done_cyc_q[bd] - t0, 1 + K * (lat + 2));
      end
    end
  endtask

  task automatic test_host_pending();
    int be;
    bit ok;
    eng_lat = 10;
    be = en_cyc_q.size();
    for (int k = 0; k < 25; k++) begin
      host_req = (k < 20);
      start = (k == 5);
      tick();
      n_vec++;
      if (s_host_gnt !== (k >= 1 && k <= 20) || s_busy !== (k >= 22) || s_eng_enable !== (k == 22)) begin
        n_err++;
        $display("FAIL host_pending_c%0d gnt=%b busy=%b en=%b required gnt=%b busy=%b en=%b",
                 k, s_host_gnt, s_busy, s_eng_enable, (k >= 1 && k <= 20), (k >= 22), (k == 22));
      end
    end
    start = 1'b0; host_req = 1'b0;
    run_to_idle(200, ok);
    n_vec++;
    if (!ok || en_cyc_q.size() - be !== K) begin
      n_err++;
      $display("FAIL host_pending_run idle=%0b launches=%0d required idle launches=%0d",
               ok, en_cyc_q.size() - be, K);
    end
  endtask

  task automatic test_start_with_req();
    int t0, fin, lat;
    lat = 7; eng_lat = lat;
    host_req = 1'b1; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    fin = t0 + 1 + K * (lat + 2);
    n_vec++;
    if (s_host_gnt !== 1'b0) begin n_err++; $display("FAIL race_gnt_first got=1 required=0"); end
    while (s_cyc < fin + 2) begin
      tick();
      n_vec++;
      if (s_host_gnt !== (s_cyc > fin) || s_done !== (s_cyc == fin) || (s_host_gnt && s_busy)) begin
        n_err++;
        $display("FAIL race_c%0d gnt=%b done=%b busy=%b required gnt=%b done=%b",
                 s_cyc - t0, s_host_gnt, s_done, s_busy, (s_cyc > fin), (s_cyc == fin));
      end
    end
    host_req = 1'b0;
    tick(); tick();
    n_vec++;
    if (s_host_gnt !== 1'b0) begin n_err++; $display("FAIL race_release got=1 required=0"); end
  endtask

  task automatic test_reset_mid_run();
    int t0, be, bd;
    bit found, ok;
    eng_lat = 30;
    bd = done_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = s_eng_enable && s_poly_sel == 2'd1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL midrst_second_launch not seen required seen"); end
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    n_vec++;
    if ({s_eng_enable, s_poly_sel, s_busy, s_done, s_host_gnt, s_err} !== 7'b0) begin
      n_err++;
      $display("FAIL midrst_outputs got=%b required=0000000",
               {s_eng_enable, s_poly_sel, s_busy, s_done, s_host_gnt, s_err});
    end
    tick();
    reset_n = 1'b1;
    repeat (80) tick();
    n_vec++;
    if (done_cyc_q.size() !== bd || s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_done dones=%0d busy=%b required dones=0 busy=0",
               done_cyc_q.size() - bd, s_busy);
    end
    eng_lat = 6;
    be = en_cyc_q.size();
    t0 = cyc; start = 1'b1; tick(); start = 1'b0;
    run_to_idle(200, ok);
    n_vec++;
    if (!ok || en_cyc_q.size() - be !== K || en_cyc_q[be] !== t0 + 1 || en_sel_q[be] !== 0) begin
      n_err++;
      $display("FAIL midrst_rerun idle=%0b launches=%0d first_at=%0d first_sel=%0d required 1 %0d 1 0",
               ok, en_cyc_q.size() - be, en_cyc_q[be] - t0, en_sel_q[be], K);
    end
  endtask

  task automatic test_spurious();
    int t0, be, bd, lat;
    bit ok;
    lat = 15; eng_lat = lat;
    be = en_cyc_q.size(); bd = done_cyc_q.size();
    eng_done_man = 1'b1; tick(); eng_done_man = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (s_busy !== 1'b0 || en_cyc_q.size() !== be) begin
      n_err++;
      $display("FAIL spur_idle busy=%b launches=%0d required 0 0", s_busy, en_cyc_q.size() - be);
    end
    t0 = cyc; start = 1'b1; tick(); start = 1'b0;
    eng_done_man = 1'b1; tick(); eng_done_man = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    run_to_idle(300, ok);
    repeat (20) tick();
    n_vec++;
    if (!ok || en_cyc_q.size() - be !== K || en_cyc_q[be+1] !== t0 + 1 + lat + 2) begin
      n_err++;
      $display("FAIL spur_run idle=%0b launches=%0d second_at=%0d required 1 %0d %0d",
               ok, en_cyc_q.size() - be, en_cyc_q[be+1] - t0, K, 1 + lat + 2);
    end
    n_vec++;
    if (done_cyc_q.size() !== bd + 1 || done_cyc_q[bd] !== t0 + 1 + K * (lat + 2) || s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL spur_done count=%0d at=%0d busy=%b required 1 %0d 0",
               done_cyc_q.size() - bd, done_cyc_q[bd] - t0, s_busy, 1 + K * (lat + 2));
    end
  endtask

`ifdef POLYVEC_REDUCE_TIMEOUT_EN
  task automatic test_watchdog();
    int t0, bd;
    bit ok;
    eng_auto = 1'b0;
    bd = done_cyc_q.size();
    t0 = cyc; start = 1'b1; tick(); start = 1'b0;
    run_to_idle(TMO + 50, ok);
    n_vec++;
    if (!ok || done_cyc_q.size() !== bd + 1 || done_cyc_q[bd] !== t0 + 2 + TMO || done_err_q[bd] !== 1) begin
      n_err++;
      $display("FAIL wdog_done idle=%0b count=%0d at=%0d err=%0d required 1 1 %0d 1",
               ok, done_cyc_q.size() - bd, done_cyc_q[bd] - t0, done_err_q[bd], 2 + TMO);
    end
    repeat (3) tick();
    n_vec++;
    if (s_err !== 1'b1) begin n_err++; $display("FAIL wdog_sticky got=%b required=1", s_err); end
    eng_auto = 1'b1; eng_lat = 5;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_vec++;
    if (s_err !== 1'b0 || s_busy !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_clear err=%b busy=%b required 0 1", s_err, s_busy);
    end
    run_to_idle(100, ok);
  endtask
`else
  task automatic test_watchdog();
    int bd;
    bit ok;
    eng_auto = 1'b0;
    bd = done_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    repeat (600) tick();
    n_vec++;
    if (s_busy !== 1'b1 || s_err !== 1'b0 || done_cyc_q.size() !== bd) begin
      n_err++;
      $display("FAIL nowdog_wait busy=%b err=%b dones=%0d required 1 0 0",
               s_busy, s_err, done_cyc_q.size() - bd);
    end
    for (int i = 0; i < K; i++) begin
      eng_done_man = 1'b1; tick(); eng_done_man = 1'b0;
      tick(); tick();
    end
    eng_auto = 1'b1;
    run_to_idle(20, ok);
    n_vec++;
    if (!ok || done_cyc_q.size() !== bd + 1 || done_err_q[bd] !== 0) begin
      n_err++;
      $display("FAIL nowdog_finish idle=%0b dones=%0d err=%0d required 1 1 0",
               ok, done_cyc_q.size() - bd, done_err_q[bd]);
    end
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic_k2();
    test_random_runs();
    test_host_pending();
    test_start_with_req();
    test_reset_mid_run();
    test_spurious();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout bench did not complete, cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
